// File: rtl/seq_core.sv
// seq_core: 6502 instruction sequencer. It loads the reset vector, then runs fetch/decode/operand/execute
// over a byte-wide read port with wait states. It implements NOP, LDA #imm, JMP abs and JMP (ind).
module seq_core #(
    parameter logic [15:0] RESET_VEC    = 16'hFFFC,
    parameter bit          JMP_IND_BUG  = 1'b1,
    parameter bit          ILLEGAL_HALT = 1'b0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  mem_rd_data,
    input  logic        mem_ready,
    output logic [15:0] mem_addr,
    output logic        mem_rd_en,
    output logic        sync,
    output logic [15:0] pc,
    output logic [7:0]  ir,
    output logic [7:0]  a_reg,
    output logic        flag_z,
    output logic        flag_n,
    output logic        illegal,
    output logic        halted
);

    typedef enum logic [3:0] {
        S_RESET   = 4'd0,
        S_VEC_LO  = 4'd1,
        S_VEC_HI  = 4'd2,
        S_FETCH   = 4'd3,
        S_OPER_LO = 4'd4,
        S_OPER_HI = 4'd5,
        S_IND_LO  = 4'd6,
        S_IND_HI  = 4'd7,
        S_EXECUTE = 4'd8,
        S_HALT    = 4'd9
    } state_t;

    localparam logic [7:0] OP_NOP  = 8'hEA;
    localparam logic [7:0] OP_LDA  = 8'hA9;
    localparam logic [7:0] OP_JMP  = 8'h4C;
    localparam logic [7:0] OP_JMPI = 8'h6C;

    state_t      r_state;
    logic [15:0] r_pc;
    logic [7:0]  r_ir;
    logic [7:0]  r_a;
    logic        r_z;
    logic        r_n;
    logic        r_illegal;
    logic [7:0]  r_op_lo;
    logic [7:0]  r_op_hi;
    logic [7:0]  r_tgt_lo;
    logic [7:0]  r_tgt_hi;

    logic [15:0] w_addr;
    logic        w_rd_en;
    logic [7:0]  w_op_lo_inc;
    logic [15:0] w_ptr;
    logic [15:0] w_ptr_inc;

    assign w_op_lo_inc = r_op_lo + 8'd1;
    assign w_ptr       = {r_op_hi, r_op_lo};
    // NMOS quirk: the high pointer byte comes from the same page as the low byte
    assign w_ptr_inc   = JMP_IND_BUG ? {r_op_hi, w_op_lo_inc} : (w_ptr + 16'd1);

    // Read address and request decoded from the current state
    always_comb begin
        w_rd_en = 1'b0;
        w_addr  = r_pc;
        case (r_state)
            S_VEC_LO:  begin w_rd_en = 1'b1; w_addr = RESET_VEC;          end
            S_VEC_HI:  begin w_rd_en = 1'b1; w_addr = RESET_VEC + 16'd1;  end
            S_FETCH:   begin w_rd_en = 1'b1; w_addr = r_pc;               end
            S_OPER_LO: begin w_rd_en = 1'b1; w_addr = r_pc;               end
            S_OPER_HI: begin w_rd_en = 1'b1; w_addr = r_pc;               end
            S_IND_LO:  begin w_rd_en = 1'b1; w_addr = w_ptr;              end
            S_IND_HI:  begin w_rd_en = 1'b1; w_addr = w_ptr_inc;          end
            default:   begin w_rd_en = 1'b0; w_addr = r_pc;               end
        endcase
    end

    // Sequencer state and architectural registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state   <= S_RESET;
            r_pc      <= 16'h0000;
            r_ir      <= OP_NOP;
            r_a       <= 8'h00;
            r_z       <= 1'b0;
            r_n       <= 1'b0;
            r_illegal <= 1'b0;
            r_op_lo   <= 8'h00;
            r_op_hi   <= 8'h00;
            r_tgt_lo  <= 8'h00;
            r_tgt_hi  <= 8'h00;
        end else begin
            r_illegal <= 1'b0;
            case (r_state)
                S_RESET: r_state <= S_VEC_LO;
                S_VEC_LO: if (mem_ready) begin
                    r_tgt_lo <= mem_rd_data;
                    r_state  <= S_VEC_HI;
                end
                S_VEC_HI: if (mem_ready) begin
                    r_pc    <= {mem_rd_data, r_tgt_lo};
                    r_state <= S_FETCH;
                end
                S_FETCH: if (mem_ready) begin
                    r_ir <= mem_rd_data;
                    r_pc <= r_pc + 16'd1;
                    case (mem_rd_data)
                        OP_NOP:  r_state <= S_EXECUTE;
                        OP_LDA:  r_state <= S_OPER_LO;
                        OP_JMP:  r_state <= S_OPER_LO;
                        OP_JMPI: r_state <= S_OPER_LO;
                        default: begin
                            r_illegal <= 1'b1;
                            r_state   <= ILLEGAL_HALT ? S_HALT : S_EXECUTE;
                        end
                    endcase
                end
                S_OPER_LO: if (mem_ready) begin
                    r_op_lo <= mem_rd_data;
                    r_pc    <= r_pc + 16'd1;
                    r_state <= (r_ir == OP_LDA) ? S_EXECUTE : S_OPER_HI;
                end
                S_OPER_HI: if (mem_ready) begin
                    r_op_hi <= mem_rd_data;
                    r_pc    <= r_pc + 16'd1;
                    r_state <= (r_ir == OP_JMP) ? S_EXECUTE : S_IND_LO;
                end
                S_IND_LO: if (mem_ready) begin
                    r_tgt_lo <= mem_rd_data;
                    r_state  <= S_IND_HI;
                end
                S_IND_HI: if (mem_ready) begin
                    r_tgt_hi <= mem_rd_data;
                    r_state  <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    case (r_ir)
                        OP_LDA: begin
                            r_a <= r_op_lo;
                            r_z <= (r_op_lo == 8'h00);
                            r_n <= r_op_lo[7];
                        end
                        OP_JMP:  r_pc <= {r_op_hi, r_op_lo};
                        OP_JMPI: r_pc <= {r_tgt_hi, r_tgt_lo};
                        default: r_pc <= r_pc;
                    endcase
                    r_state <= S_FETCH;
                end
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_RESET;
            endcase
        end
    end

    assign mem_addr  = w_addr;
    assign mem_rd_en = w_rd_en;
    assign sync      = (r_state == S_FETCH);
    assign halted    = (r_state == S_HALT);
    assign pc        = r_pc;
    assign ir        = r_ir;
    assign a_reg     = r_a;
    assign flag_z    = r_z;
    assign flag_n    = r_n;
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_seq_core.sv
// Self-checking bench for seq_core: two instances (NMOS/continue, fixed/halt) share one memory.
// Expected fetch events are queued as programs are loaded and compared as fetches complete.
module tb_seq_core;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_ready;
    logic [7:0]  mem [0:65535];

    logic [15:0] addr0, pc0, addr1, pc1;
    logic [7:0]  rd0, ir0, a0, rd1, ir1, a1;
    logic        en0, sync0, z0, n0, ill0, h0;
    logic        en1, sync1, z1, n1, ill1, h1;

    assign rd0 = mem[addr0];
    assign rd1 = mem[addr1];

    always #5 clk = ~clk;

    seq_core #(.RESET_VEC(16'hFFFC), .JMP_IND_BUG(1'b1), .ILLEGAL_HALT(1'b0)) dut0 (
        .clk(clk), .resetn(resetn), .mem_rd_data(rd0), .mem_ready(mem_ready),
        .mem_addr(addr0), .mem_rd_en(en0), .sync(sync0), .pc(pc0), .ir(ir0),
        .a_reg(a0), .flag_z(z0), .flag_n(n0), .illegal(ill0), .halted(h0)
    );

    seq_core #(.RESET_VEC(16'hFFFC), .JMP_IND_BUG(1'b0), .ILLEGAL_HALT(1'b1)) dut1 (
        .clk(clk), .resetn(resetn), .mem_rd_data(rd1), .mem_ready(mem_ready),
        .mem_addr(addr1), .mem_rd_en(en1), .sync(sync1), .pc(pc1), .ir(ir1),
        .a_reg(a1), .flag_z(z1), .flag_n(n1), .illegal(ill1), .halted(h1)
    );

    typedef struct {
        logic [15:0] addr;
        int          gap;
        logic [7:0]  a;
        logic        z;
        logic        n;
    } fetch_t;

    typedef struct {
        logic [7:0] imm;
        logic [7:0] exp_a;
        logic       exp_z;
        logic       exp_n;
    } lda_vec_t;

    fetch_t sb_q[$];
    bit     sb_en = 1'b0;
    int     cyc = 0;
    int     last_fetch = 0;
    int     ill_cnt0 = 0;
    int     ill_cnt1 = 0;
    int     n_checks = 0;
    int     n_pass = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] a, input int g, input logic [7:0] acc,
                        input logic z, input logic n);
        fetch_t e;
        e.addr = a; e.gap = g; e.a = acc; e.z = z; e.n = n;
        sb_q.push_back(e);
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 65536; i++) mem[i] = 8'hEA;
        mem[16'hFFFC] = 8'h00;
        mem[16'hFFFD] = 8'h80;
    endtask

    task automatic hold_reset();
        resetn    = 1'b0;
        mem_ready = 1'b1;
        tick();
        tick();
    endtask

    // release reset and follow the two vector reads into the first fetch
    task automatic release_vec(input logic [15:0] first_pc);
        resetn     = 1'b1;
        last_fetch = cyc;
        tick();
        check("vec_lo_addr", addr0, 16'hFFFC);
        check("vec_lo_en", en0, 1'b1);
        check("vec_lo_sync", sync0, 1'b0);
        tick();
        check("vec_hi_addr", addr0, 16'hFFFD);
        tick();
        check("first_fetch_addr", addr0, first_pc);
        check("first_fetch_sync", sync0, 1'b1);
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && sb_q.size() != 0; i++) tick();
        check("sb_drained", sb_q.size(), 0);
        sb_en = 1'b0;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard: compare each completing fetch of dut0 with the next expected record
    always @(negedge clk) begin
        fetch_t e;
        if (ill0) ill_cnt0++;
        if (ill1) ill_cnt1++;
        if (sb_en && sync0 && mem_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_fetch: got %0h, expected no fetch", addr0);
            end else begin
                e = sb_q.pop_front();
                check("fetch_addr", addr0, e.addr);
                check("fetch_gap", cyc - last_fetch, e.gap);
                check("a_reg", a0, e.a);
                check("flag_z", z0, e.z);
                check("flag_n", n0, e.n);
            end
            last_fetch = cyc;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected $finish");
        $fatal(1);
    end

    initial begin
        lda_vec_t    lda_tab [4];
        logic [15:0] p;
        logic [7:0]  ca;
        logic        cz, cn;

        lda_tab[0] = '{8'h00, 8'h00, 1'b1, 1'b0};
        lda_tab[1] = '{8'h80, 8'h80, 1'b0, 1'b1};
        lda_tab[2] = '{8'h7F, 8'h7F, 1'b0, 1'b0};
        lda_tab[3] = '{8'hFF, 8'hFF, 1'b0, 1'b1};

        resetn    = 1'b0;
        mem_ready = 1'b1;
        fill_mem();
        tick();
        tick();
        check("rst_pc", pc0, 16'h0000);
        check("rst_ir", ir0, 8'hEA);
        check("rst_a", a0, 8'h00);
        check("rst_z", z0, 1'b0);
        check("rst_n", n0, 1'b0);
        check("rst_illegal", ill0, 1'b0);
        check("rst_halted", h0, 1'b0);
        check("rst_sync", sync0, 1'b0);
        check("rst_rd_en", en0, 1'b0);
        check("rst_addr", addr0, 16'h0000);

        // main program: LDA table, NOP, JMP abs, JMP (ind) across a page end, illegal opcode
        p = 16'h8000; ca = 8'h00; cz = 1'b0; cn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem[p] = 8'hA9;
            mem[p + 16'd1] = lda_tab[i].imm;
            push(p, 3, ca, cz, cn);
            ca = lda_tab[i].exp_a; cz = lda_tab[i].exp_z; cn = lda_tab[i].exp_n;
            p = p + 16'd2;
        end
        mem[p] = 8'hEA;
        push(p, 3, ca, cz, cn);
        p = p + 16'd1;
        mem[p] = 8'h4C; mem[p + 16'd1] = 8'h34; mem[p + 16'd2] = 8'h12;
        push(p, 2, ca, cz, cn);
        mem[16'h1234] = 8'h6C; mem[16'h1235] = 8'hFF; mem[16'h1236] = 8'h30;
        push(16'h1234, 4, ca, cz, cn);
        mem[16'h30FF] = 8'h40; mem[16'h3000] = 8'h50; mem[16'h3100] = 8'h60;
        mem[16'h5040] = 8'h02; mem[16'h6040] = 8'h02;
        push(16'h5040, 6, ca, cz, cn);
        push(16'h5041, 2, ca, cz, cn);
        push(16'h5042, 2, ca, cz, cn);
        ill_cnt0 = 0; ill_cnt1 = 0;
        sb_en = 1'b1;
        release_vec(16'h8000);
        drain();
        check("illegal_pulses_dut0", ill_cnt0, 1);
        check("halted_dut0", h0, 1'b0);
        check("halted_dut1", h1, 1'b1);
        check("halt_rd_en_dut1", en1, 1'b0);
        check("halt_pc_dut1", pc1, 16'h6041);
        check("halt_ir_dut1", ir1, 8'h02);
        check("illegal_pulses_dut1", ill_cnt1, 1);
        repeat (10) tick();
        check("halt_held_dut1", h1, 1'b1);
        check("halt_held_pc_dut1", pc1, 16'h6041);
        check("halt_held_rd_en_dut1", en1, 1'b0);

        // JMP abs with two wait states during the high operand read
        fill_mem();
        mem[16'h8000] = 8'h4C; mem[16'h8001] = 8'h34; mem[16'h8002] = 8'h12;
        hold_reset();
        check("halt_cleared_dut1", h1, 1'b0);
        push(16'h8000, 3, 8'h00, 1'b0, 1'b0);
        push(16'h1234, 6, 8'h00, 1'b0, 1'b0);
        sb_en = 1'b1;
        release_vec(16'h8000);
        for (int i = 0; i < 20 && !(addr0 == 16'h8002 && en0); i++) tick();
        check("reach_oper_hi", addr0, 16'h8002);
        mem_ready = 1'b0;
        tick();
        check("stall1_addr", addr0, 16'h8002);
        check("stall1_en", en0, 1'b1);
        tick();
        check("stall2_addr", addr0, 16'h8002);
        mem_ready = 1'b1;
        tick();
        check("exec_rd_en", en0, 1'b0);
        check("exec_addr", addr0, 16'h8003);
        tick();
        check("jmp_fetch_addr", addr0, 16'h1234);
        check("jmp_fetch_sync", sync0, 1'b1);
        drain();

        // reset asserted during IND_LO reloads the vector
        fill_mem();
        mem[16'h8000] = 8'h6C; mem[16'h8001] = 8'h00; mem[16'h8002] = 8'h90;
        hold_reset();
        release_vec(16'h8000);
        for (int i = 0; i < 20 && !(addr0 == 16'h9000 && en0); i++) tick();
        check("reach_ind_lo", addr0, 16'h9000);
        resetn = 1'b0;
        tick();
        check("midrst_rd_en", en0, 1'b0);
        check("midrst_addr", addr0, 16'h0000);
        check("midrst_pc", pc0, 16'h0000);
        check("midrst_sync", sync0, 1'b0);
        push(16'h8000, 3, 8'h00, 1'b0, 1'b0);
        sb_en = 1'b1;
        release_vec(16'h8000);
        drain();

        // NOP at FFFF wraps the next fetch to 0000
        fill_mem();
        mem[16'hFFFC] = 8'hFF; mem[16'hFFFD] = 8'hFF;
        hold_reset();
        push(16'hFFFF, 3, 8'h00, 1'b0, 1'b0);
        push(16'h0000, 2, 8'h00, 1'b0, 1'b0);
        sb_en = 1'b1;
        release_vec(16'hFFFF);
        drain();
        check("wrap_pc", pc0, 16'h0001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
